// File: rtl/bus_receiver_pkg.sv
// Shared frame layout, FSM state type and serial CRC-4 step for the bus receiver and its senders.
package bus_receiver_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_CRC  = 2'd3
  } rx_state_e;

  localparam int ADDR_W    = 4;
  localparam int DATA_W    = 64;
  localparam int CRC_W     = 4;
  localparam int FRAME_LEN = 1 + ADDR_W + DATA_W + CRC_W;  // 73 bits including start bit
  localparam int CNT_W     = 7;

  // x^4 + x + 1, implicit x^4 term
  localparam logic [CRC_W-1:0] CRC_POLY = 4'h3;

  function automatic logic [CRC_W-1:0] crc4_step(input logic [CRC_W-1:0] rem, input logic b);
    logic fb;
    fb = b ^ rem[CRC_W-1];
    return {rem[CRC_W-2:0], 1'b0} ^ (fb ? CRC_POLY : '0);
  endfunction

endpackage

// File: rtl/bus_receiver_crc4_serial.sv
// Bit-serial CRC-4 (x^4+x+1, init 0, no reflection, no final XOR), shared with the senders.
module crc4_serial
  import bus_receiver_pkg::*;
(
  input  logic             clk_i,
  input  logic             clear_i,
  input  logic             en_i,
  input  logic             bit_i,
  output logic [CRC_W-1:0] rem_o
);

  logic [CRC_W-1:0] rem_q;
  logic [CRC_W-1:0] rem_d;

  always_comb begin
    rem_d = rem_q;
    if (clear_i) begin
      rem_d = '0;
    end else if (en_i) begin
      rem_d = crc4_step(rem_q, bit_i);
    end
  end

  always_ff @(posedge clk_i) begin
    rem_q <= rem_d;
  end

  assign rem_o = rem_q;

endmodule

// File: rtl/bus_receiver.sv
// Serial frame receiver: start bit, 4-bit address, 64-bit data, 4-bit CRC, one bit per clock.
// CRC checking is built only when BUS_RECEIVER_CRC_CHECK_EN is defined.
module bus_receiver
  import bus_receiver_pkg::*;
#(
  parameter logic [ADDR_W-1:0] MY_ADDR = 4'd1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              bus_in,
  input  logic              data_ready,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              crc_err,
  output logic              overrun
);

  localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_W - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] CRC_LAST  = CNT_W'(CRC_W - 1);

  rx_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic              valid_q, valid_d;
  logic              crc_err_q, crc_err_d;
  logic              overrun_q, overrun_d;
  logic              addr_en, data_en, frame_done;
  logic              crc_ok, addr_hit, accept, consume;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Counter restarts at zero on every state entry.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (bus_in) state_d = ST_ADDR;
      end
      ST_ADDR: if (cnt_q == ADDR_LAST) begin
        state_d = ST_DATA;
        cnt_d   = '0;
      end
      ST_DATA: if (cnt_q == DATA_LAST) begin
        state_d = ST_CRC;
        cnt_d   = '0;
      end
      ST_CRC: if (cnt_q == CRC_LAST) begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    addr_en    = 1'b0;
    data_en    = 1'b0;
    frame_done = 1'b0;
    unique case (state_q)
      ST_ADDR: addr_en    = 1'b1;
      ST_DATA: data_en    = 1'b1;
      ST_CRC:  frame_done = (cnt_q == CRC_LAST);
      default: ;
    endcase
  end

  assign addr_d  = addr_en ? {addr_q[ADDR_W-2:0], bus_in} : addr_q;
  assign shift_d = data_en ? {shift_q[DATA_W-2:0], bus_in} : shift_q;

  always_ff @(posedge clock) begin
    addr_q  <= addr_d;
    shift_q <= shift_d;
  end

`ifdef BUS_RECEIVER_CRC_CHECK_EN
  logic [CRC_W-1:0] crc_rem;
  logic [CRC_W-2:0] crc_rx_q;

  crc4_serial u_crc (
    .clk_i   (clock),
    .clear_i (reset || (state_q == ST_IDLE)),
    .en_i    (addr_en || data_en),
    .bit_i   (bus_in),
    .rem_o   (crc_rem)
  );

  always_ff @(posedge clock) begin
    if (state_q == ST_CRC) crc_rx_q <= {crc_rx_q[CRC_W-3:0], bus_in};
  end

  // The last CRC bit is compared straight off the bus on the deciding edge.
  assign crc_ok = ({crc_rx_q, bus_in} == crc_rem);
`else
  assign crc_ok = 1'b1;
`endif

  assign addr_hit = (addr_q == MY_ADDR);
  assign consume  = valid_q && data_ready;
  assign accept   = frame_done && addr_hit && crc_ok;

  always_comb begin
    data_out_d = data_out_q;
    valid_d    = valid_q && !consume;
    overrun_d  = 1'b0;
    crc_err_d  = frame_done && addr_hit && !crc_ok;
    if (accept) begin
      if (!valid_q || consume) begin
        data_out_d = shift_q;
        valid_d    = 1'b1;
      end else begin
        overrun_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      data_out_q <= '0;
      valid_q    <= 1'b0;
      crc_err_q  <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      data_out_q <= data_out_d;
      valid_q    <= valid_d;
      crc_err_q  <= crc_err_d;
      overrun_q  <= overrun_d;
    end
  end

  assign data_out   = data_out_q;
  assign data_valid = valid_q;
  assign crc_err    = crc_err_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_bus_receiver.sv
// Directed bench for bus_receiver: hand-computed CRC-4 frames, outputs sampled 1 time unit after each edge.
module tb_bus_receiver;

  logic        clock = 1'b0;
  logic        reset;
  logic        bus_in;
  logic        data_ready;
  logic [63:0] data_out;
  logic        data_valid;
  logic        crc_err;
  logic        overrun;

  int checks   = 0;
  int failures = 0;

  bus_receiver #(.MY_ADDR(4'd1)) dut (
    .clock      (clock),
    .reset      (reset),
    .bus_in     (bus_in),
    .data_ready (data_ready),
    .data_out   (data_out),
    .data_valid (data_valid),
    .crc_err    (crc_err),
    .overrun    (overrun)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Drives n bits of frame f starting at bit index 'from' (0 = start bit), then idles the bus.
  task automatic send(input logic [72:0] f, input int from, input int n);
    for (int i = 0; i < n; i++) begin
      bus_in = f[72-from-i];
      @(posedge clock);
      #1;
    end
    bus_in = 1'b0;
  endtask

  function automatic logic [72:0] frame(input logic [3:0] a, input logic [63:0] d, input logic [3:0] c);
    return {1'b1, a, d, c};
  endfunction

  logic [72:0] f_a1_d1, f_bad, f_a2, f_a1_d2, f_a1_d3;

  initial begin
    // CRC values: remainder of (addr,data)*x^4 mod x^4+x+1
    f_a1_d1 = frame(4'h1, 64'h1, 4'h6);
    f_bad   = frame(4'h1, 64'h1, 4'h1);
    f_a2    = frame(4'h2, 64'h1, 4'h9);
    f_a1_d2 = frame(4'h1, 64'h2, 4'h3);
    f_a1_d3 = frame(4'h1, 64'h3, 4'h0);

    reset      = 1'b1;
    bus_in     = 1'b0;
    data_ready = 1'b0;
    tick(2);
    check1 ("rst_valid",   data_valid, 1'b0);
    check64("rst_data",    data_out,   64'h0);
    check1 ("rst_crc_err", crc_err,    1'b0);
    check1 ("rst_overrun", overrun,    1'b0);
    reset = 1'b0;
    tick(1);

    // Good addressed frame, latency 1, consumed immediately
    data_ready = 1'b1;
    send(f_a1_d1, 0, 72);
    check1 ("good_before_last", data_valid, 1'b0);
    send(f_a1_d1, 72, 1);
    check1 ("good_valid",   data_valid, 1'b1);
    check64("good_data",    data_out,   64'h1);
    check1 ("good_crc_err", crc_err,    1'b0);
    check1 ("good_overrun", overrun,    1'b0);
    tick(1);
    check1 ("good_consumed", data_valid, 1'b0);

    // Bad CRC frame
    send(f_bad, 0, 73);
`ifdef BUS_RECEIVER_CRC_CHECK_EN
    check1 ("bad_crc_err",  crc_err,    1'b1);
    check1 ("bad_valid",    data_valid, 1'b0);
    tick(1);
    check1 ("bad_crc_err_pulse", crc_err,    1'b0);
    check1 ("bad_valid_after",   data_valid, 1'b0);
`else
    check1 ("nocrc_valid",   data_valid, 1'b1);
    check64("nocrc_data",    data_out,   64'h1);
    check1 ("nocrc_crc_err", crc_err,    1'b0);
    tick(1);
    check1 ("nocrc_consumed", data_valid, 1'b0);
`endif

    // Frame for another station
    send(f_a2, 0, 73);
    check1("other_valid",   data_valid, 1'b0);
    check1("other_crc_err", crc_err,    1'b0);
    check1("other_overrun", overrun,    1'b0);
    tick(1);
    check1("other_valid_late", data_valid, 1'b0);

    // Back-to-back frames, consumer stalled
    data_ready = 1'b0;
    send(f_a1_d1, 0, 73);
    check1 ("b2b_first_valid",   data_valid, 1'b1);
    check64("b2b_first_data",    data_out,   64'h1);
    check1 ("b2b_first_overrun", overrun,    1'b0);
    send(f_a1_d2, 0, 73);
    check1 ("b2b_overrun",       overrun,    1'b1);
    check1 ("b2b_valid",         data_valid, 1'b1);
    check64("b2b_data_kept",     data_out,   64'h1);
    tick(1);
    check1 ("b2b_overrun_pulse", overrun,    1'b0);
    check1 ("b2b_valid_hold",    data_valid, 1'b1);
    check64("b2b_data_hold",     data_out,   64'h1);

    // Consume and load on the same edge
    send(f_a1_d2, 0, 72);
    data_ready = 1'b1;
    send(f_a1_d2, 72, 1);
    check1 ("swap_valid",   data_valid, 1'b1);
    check64("swap_data",    data_out,   64'h2);
    check1 ("swap_overrun", overrun,    1'b0);
    tick(1);
    check1 ("swap_consumed", data_valid, 1'b0);

    // Reset in the middle of the data field, then a full good frame
    send(f_a1_d1, 0, 35);
    reset  = 1'b1;
    bus_in = f_a1_d1[72-35];
    tick(1);
    reset  = 1'b0;
    bus_in = 1'b0;
    check64("midrst_data",  data_out,   64'h0);
    check1 ("midrst_valid", data_valid, 1'b0);
    tick(2);
    check1 ("midrst_idle_valid", data_valid, 1'b0);
    send(f_a1_d3, 0, 73);
    check1 ("after_rst_valid",   data_valid, 1'b1);
    check64("after_rst_data",    data_out,   64'h3);
    check1 ("after_rst_crc_err", crc_err,    1'b0);
    check1 ("after_rst_overrun", overrun,    1'b0);
    tick(1);
    check1 ("after_rst_consumed", data_valid, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bus_receiver.md
BUS_RECEIVER -- requirements
Module: bus_receiver

Interface
REQ-001 SHALL have parameter MY_ADDR, default 4'd1, the station address this receiver accepts.
REQ-002 SHALL have port clock, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1; reset is synchronous and active-high.
REQ-004 SHALL have port bus_in, input, 1, the serial frame bus from the 16-sender bus arbiter (its bus_out).
REQ-005 SHALL have port data_ready, input, 1, consumer accepts data_out when high with data_valid.
REQ-006 SHALL have port data_out, output, 64, payload of the last accepted frame.
REQ-007 SHALL have port data_valid, output, 1, data_out holds an unconsumed frame.
REQ-008 SHALL have port crc_err, output, 1, one-cycle pulse on an addressed frame with bad CRC.
REQ-009 SHALL have port overrun, output, 1, one-cycle pulse on an addressed good frame dropped because the buffer is full.

Function
REQ-010 SHALL decode this frame: idle bus=0; start bit=1; 4-bit receiver address, MSB first; 64-bit data, MSB first; 4-bit CRC, MSB first; 73 bits, one bit per clock.
REQ-011 SHALL use FSM states IDLE, ADDR, DATA, CRC: IDLE->ADDR when bus_in=1; ADDR->DATA after 4 bits; DATA->CRC after 64 bits; CRC->IDLE after 4 bits.
REQ-012 SHALL use a single 7-bit bit counter cleared on every state entry.
REQ-013 SHALL compute CRC-4 with polynomial x^4+x+1 (0x3), init 0, no reflection, no final XOR, over the 68 address+data bits, serially as they arrive.
REQ-014 SHALL evaluate a frame on the edge sampling the last CRC bit and return to IDLE on that edge, so a start bit in the next cycle begins a new frame (zero-gap back-to-back frames).
REQ-015 SHALL ignore frames whose address differs from MY_ADDR: no output, no pulses.
REQ-016 SHALL, for an addressed good frame with buffer empty (or being drained that same cycle), load data_out and set data_valid on the cycle after the last CRC bit (latency 1).
REQ-017 SHALL hold data_out and data_valid stable until data_valid&&data_ready, then clear data_valid on the next edge.
REQ-018 SHALL, when load and consume coincide, load the new frame and keep data_valid=1.
REQ-019 SHALL, for an addressed good frame while data_valid=1 and data_ready=0, drop the frame, keep the old data, and pulse overrun.
REQ-020 SHALL pulse crc_err for one cycle, 1 cycle after the last CRC bit, on an addressed frame with CRC mismatch; the frame is dropped.

Reset
REQ-021 SHALL, on reset=1 at a rising edge, set FSM=IDLE, counter=0, CRC register=0, data_out=0, data_valid=0, crc_err=0, overrun=0.
REQ-022 SHALL abandon a frame when reset is asserted mid-frame; bits after release are decoded from IDLE.

Configuration
REQ-023 SHALL provide macro BUS_RECEIVER_CRC_CHECK_EN: defined -> REQ-013/REQ-020 are active; undefined -> no CRC logic, the CRC field is clocked through and discarded, every addressed frame counts as good, and crc_err is tied to 0.

Structure
REQ-024 SHALL place in a shared package: the FSM state typedef, the frame field widths (ADDR_W=4, DATA_W=64, CRC_W=4), the CRC polynomial constant, and the frame length 73.
REQ-025 SHALL use one sub-module crc4_serial (clear, enable, bit in, 4-bit remainder out), which senders may reuse.

Verification
REQ-026 SHALL verify that with MY_ADDR=1, a frame addr=1, data=64'h1, crc=4'h6 and data_ready=1 sets data_valid=1 with data_out=64'h1 exactly 1 cycle after the last CRC bit, then clears it after 1 cycle.
REQ-027 SHALL verify that with the same frame but crc=4'h1, crc_err pulses once and data_valid stays 0; with the macro undefined, the frame is accepted instead.
REQ-028 SHALL verify that a frame with addr=2 and a correct CRC produces no data_valid, crc_err or overrun.
REQ-029 SHALL verify that two good addressed frames back-to-back with zero gap and data_ready=0 keep the first data_out, pulse overrun once, and keep data_valid=1.
REQ-030 SHALL verify that reset asserted at data bit 30, followed by a full good frame, yields only the second frame's data.
REQ-031 SHALL verify that data_ready raised on the same cycle a new frame loads keeps data_valid=1 and presents the new data.
